// File: rtl/mem_wb_pkg.sv
// Shared definitions for the MEM/WB stage: writeback select codes, the
// mapping from select code to the writeback mux controls, and FSM states.
package mem_wb_pkg;

  // in_wb_sel codes; 2'b11 also selects PC+1
  localparam logic [1:0] WB_SEL_ALU = 2'b00;
  localparam logic [1:0] WB_SEL_MEM = 2'b01;
  localparam logic [1:0] WB_SEL_PC  = 2'b10;

  // Writeback mux select pair {controlA, controlB}
  typedef struct packed {
    logic ctrl_a;
    logic ctrl_b;
  } wb_ctrl_t;

  localparam wb_ctrl_t CTRL_ALU = '{ctrl_a: 1'b0, ctrl_b: 1'b0};
  localparam wb_ctrl_t CTRL_MEM = '{ctrl_a: 1'b1, ctrl_b: 1'b0};
  localparam wb_ctrl_t CTRL_PC  = '{ctrl_a: 1'b0, ctrl_b: 1'b1};

  // Load-wait controller states
  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_WAIT_MEM = 1'b1
  } state_t;

  // Width of the load-wait counter; covers timeouts up to 255
  localparam int CNT_W = 8;

  // Select code to mux controls; the upper code point aliases to PC
  function automatic wb_ctrl_t sel_to_ctrl(input logic [1:0] sel);
    wb_ctrl_t c;
    case (sel)
      WB_SEL_ALU: c = CTRL_ALU;
      WB_SEL_MEM: c = CTRL_MEM;
      default:    c = CTRL_PC;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/mem_wb_stage_wb_sel_decode.sv
// Combinational decode of the writeback select code into the two
// select lines of the downstream 3:1 writeback mux.
module wb_sel_decode
  import mem_wb_pkg::*;
(
  input  logic [1:0] wb_sel,
  output logic       control_a,
  output logic       control_b
);

  wb_ctrl_t ctrl;

  // Map the select code onto the mux control pair
  always_comb begin
    ctrl      = sel_to_ctrl(wb_sel);
    control_a = ctrl.ctrl_a;
    control_b = ctrl.ctrl_b;
  end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register with a load-wait controller. Non-load
// instructions retire one cycle after acceptance; loads park in WAIT_MEM
// until the data memory answers, the wait times out, or a flush kills them.
module mem_wb_stage
  import mem_wb_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int RD_W        = 6,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_alu_result,
  input  logic [DATA_W-1:0] in_pc_next,
  input  logic [RD_W-1:0]   in_rd,
  input  logic              in_reg_write,
  input  logic              in_mem_read,
  input  logic [1:0]        in_wb_sel,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_rdata_valid,
  input  logic              flush,
  output logic              wb_valid,
  output logic [DATA_W-1:0] wb_alu,
  output logic [DATA_W-1:0] wb_mem,
  output logic [DATA_W-1:0] wb_pc,
  output logic              wb_controlA,
  output logic              wb_controlB,
  output logic [RD_W-1:0]   wb_rd,
  output logic              wb_reg_write,
  output logic              mem_timeout_err
);

  // Last counter value before the wait is declared timed out
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] wait_cnt;
  logic             accept;
  logic             load_start;
  logic             load_done;
  logic             load_abort;
  logic             load_tmo;
  logic             ctrl_a_dec, ctrl_b_dec;
  logic             rw_q;

  wb_sel_decode u_sel_dec (
    .wb_sel    (in_wb_sel),
    .control_a (ctrl_a_dec),
    .control_b (ctrl_b_dec)
  );

  assign in_ready     = (state == ST_IDLE);
  assign accept       = in_valid & in_ready & ~flush;
  // Write enable is only meaningful while the pulse is up
  assign wb_reg_write = rw_q & wb_valid;

  // State register
  always_ff @(posedge clock) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  // Next state and load-wait events; flush outranks returning data,
  // returning data outranks the timeout on the final wait cycle
  always_comb begin
    state_nxt  = state;
    load_start = 1'b0;
    load_done  = 1'b0;
    load_abort = 1'b0;
    load_tmo   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept && in_mem_read) begin
          load_start = 1'b1;
          state_nxt  = ST_WAIT_MEM;
        end
      end
      ST_WAIT_MEM: begin
        if (flush) begin
          load_abort = 1'b1;
          state_nxt  = ST_IDLE;
        end else if (mem_rdata_valid) begin
          load_done = 1'b1;
          state_nxt = ST_IDLE;
        end else if (wait_cnt == CNT_LAST) begin
          load_tmo  = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Wait counter: counts cycles spent in WAIT_MEM without data
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wait_cnt <= '0;
    end else if (load_start || load_done || load_abort || load_tmo) begin
      wait_cnt <= '0;
    end else if (state == ST_WAIT_MEM) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  // Writeback registers: capture on accept, pulse valid on retirement;
  // fields hold between pulses so the mux inputs stay stable
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wb_valid        <= 1'b0;
      wb_alu          <= '0;
      wb_mem          <= '0;
      wb_pc           <= '0;
      wb_controlA     <= 1'b0;
      wb_controlB     <= 1'b0;
      wb_rd           <= '0;
      rw_q            <= 1'b0;
      mem_timeout_err <= 1'b0;
    end else begin
      wb_valid <= 1'b0;
      if (accept) begin
        wb_alu      <= in_alu_result;
        wb_pc       <= in_pc_next;
        wb_rd       <= in_rd;
        wb_controlA <= ctrl_a_dec;
        wb_controlB <= ctrl_b_dec;
        rw_q        <= in_reg_write;
        if (!in_mem_read) wb_valid <= 1'b1;
      end
      if (load_done) begin
        wb_mem   <= mem_rdata;
        wb_valid <= 1'b1;
      end
      // A timed-out load still retires, but must not write the register file
      if (load_tmo) begin
        wb_valid        <= 1'b1;
        rw_q            <= 1'b0;
        mem_timeout_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Bench for mem_wb_stage: directed vector table, hand-written timeout and
// reset-mid-load sequences, then random traffic against a transaction model.
module tb_mem_wb_stage;

  localparam int TMO = 15;

  typedef struct {
    logic        rst_n, vld;
    logic [31:0] alu, pc;
    logic [5:0]  rd;
    logic        rw, mr;
    logic [1:0]  sel;
    logic [31:0] mdata;
    logic        mv, fl;
  } in_t;

  typedef struct {
    logic        rdy, wv;
    logic [31:0] walu, wmem, wpc;
    logic        a, b;
    logic [5:0]  wrd;
    logic        wrw, err;
  } exp_t;

  typedef struct {
    bit   chk;
    in_t  i;
    exp_t e;
  } vec_t;

  logic        clock = 1'b0;
  logic        reset_n, in_valid, in_ready, in_reg_write, in_mem_read;
  logic [31:0] in_alu_result, in_pc_next, mem_rdata;
  logic [5:0]  in_rd;
  logic [1:0]  in_wb_sel;
  logic        mem_rdata_valid, flush;
  logic        wb_valid, wb_controlA, wb_controlB, wb_reg_write, mem_timeout_err;
  logic [31:0] wb_alu, wb_mem, wb_pc;
  logic [5:0]  wb_rd;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clock = ~clock;

  mem_wb_stage #(.DATA_W(32), .RD_W(6), .MEM_TIMEOUT(TMO)) dut (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_alu_result(in_alu_result), .in_pc_next(in_pc_next), .in_rd(in_rd),
    .in_reg_write(in_reg_write), .in_mem_read(in_mem_read), .in_wb_sel(in_wb_sel),
    .mem_rdata(mem_rdata), .mem_rdata_valid(mem_rdata_valid), .flush(flush),
    .wb_valid(wb_valid), .wb_alu(wb_alu), .wb_mem(wb_mem), .wb_pc(wb_pc),
    .wb_controlA(wb_controlA), .wb_controlB(wb_controlB), .wb_rd(wb_rd),
    .wb_reg_write(wb_reg_write), .mem_timeout_err(mem_timeout_err)
  );

  function automatic in_t mk_in(logic rst_n, logic vld, logic [31:0] alu, logic [31:0] pc,
                                logic [5:0] rd, logic rw, logic mr, logic [1:0] sel,
                                logic [31:0] mdata, logic mv, logic fl);
    in_t r;
    r.rst_n = rst_n; r.vld = vld; r.alu = alu; r.pc = pc; r.rd = rd; r.rw = rw;
    r.mr = mr; r.sel = sel; r.mdata = mdata; r.mv = mv; r.fl = fl;
    return r;
  endfunction

  function automatic exp_t mk_exp(logic rdy, logic wv, logic [31:0] walu, logic [31:0] wmem,
                                  logic [31:0] wpc, logic a, logic b, logic [5:0] wrd,
                                  logic wrw, logic err);
    exp_t r;
    r.rdy = rdy; r.wv = wv; r.walu = walu; r.wmem = wmem; r.wpc = wpc;
    r.a = a; r.b = b; r.wrd = wrd; r.wrw = wrw; r.err = err;
    return r;
  endfunction

  // ---------------- transaction-level reference model ----------------
  exp_t m_out;
  bit   m_busy;
  int   m_waited;
  logic m_hold_rw;

  task automatic model_edge(input in_t i);
    if (!i.rst_n) begin
      m_out     = mk_exp(1'b1, 1'b0, '0, '0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
      m_busy    = 1'b0;
      m_waited  = 0;
      m_hold_rw = 1'b0;
    end else begin
      m_out.wv  = 1'b0;
      m_out.wrw = 1'b0;
      if (!m_busy) begin
        if (i.vld && !i.fl) begin
          m_out.walu = i.alu;
          m_out.wpc  = i.pc;
          m_out.wrd  = i.rd;
          m_out.a    = (i.sel == 2'd1);
          m_out.b    = (i.sel >= 2'd2);
          m_hold_rw  = i.rw;
          if (i.mr) begin
            m_busy   = 1'b1;
            m_waited = 0;
          end else begin
            m_out.wv  = 1'b1;
            m_out.wrw = i.rw;
          end
        end
      end else if (i.fl) begin
        m_busy = 1'b0;
      end else if (i.mv) begin
        m_out.wmem = i.mdata;
        m_out.wv   = 1'b1;
        m_out.wrw  = m_hold_rw;
        m_busy     = 1'b0;
      end else begin
        m_waited++;
        if (m_waited == TMO) begin
          m_busy    = 1'b0;
          m_out.wv  = 1'b1;
          m_out.err = 1'b1;
        end
      end
      m_out.rdy = !m_busy;
    end
  endtask

  // ---------------- checking ----------------
  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask

  task automatic check_all(input string tag, input exp_t e);
    cmp({tag, ".in_ready"},     32'(in_ready),        32'(e.rdy));
    cmp({tag, ".wb_valid"},     32'(wb_valid),        32'(e.wv));
    cmp({tag, ".wb_alu"},       wb_alu,               e.walu);
    cmp({tag, ".wb_mem"},       wb_mem,               e.wmem);
    cmp({tag, ".wb_pc"},        wb_pc,                e.wpc);
    cmp({tag, ".controlA"},     32'(wb_controlA),     32'(e.a));
    cmp({tag, ".controlB"},     32'(wb_controlB),     32'(e.b));
    cmp({tag, ".wb_rd"},        32'(wb_rd),           32'(e.wrd));
    cmp({tag, ".wb_reg_write"}, 32'(wb_reg_write),    32'(e.wrw));
    cmp({tag, ".timeout_err"},  32'(mem_timeout_err), 32'(e.err));
  endtask

  // One cycle: drive inputs, check outputs mid-cycle, take the edge
  task automatic cycle(input in_t i, input bit do_chk, input exp_t e, input string tag);
    reset_n = i.rst_n; in_valid = i.vld; in_alu_result = i.alu; in_pc_next = i.pc;
    in_rd = i.rd; in_reg_write = i.rw; in_mem_read = i.mr; in_wb_sel = i.sel;
    mem_rdata = i.mdata; mem_rdata_valid = i.mv; flush = i.fl;
    #2;
    if (do_chk) check_all(tag, e);
    @(posedge clock);
    model_edge(i);
    #1;
  endtask

  vec_t  vt[21];
  in_t   idle, ri;
  exp_t  e;
  localparam logic [31:0] DB = 32'hDEAD_BEEF;

  initial begin
    idle = mk_in(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // expected outputs are those visible during the row's cycle
    vt[0]  = '{0, mk_in(0,0,0,0,0,0,0,0,0,0,0),                  mk_exp(1,0,0,0,0,0,0,0,0,0)};
    vt[1]  = '{1, idle,                                           mk_exp(1,0,0,0,0,0,0,0,0,0)};
    vt[2]  = '{1, mk_in(1,1,5,'h11,3,1,0,0,0,0,0),                mk_exp(1,0,0,0,0,0,0,0,0,0)};
    vt[3]  = '{1, mk_in(1,1,'h77,'h40,5,1,0,2,0,0,0),             mk_exp(1,1,5,0,'h11,0,0,3,1,0)};
    vt[4]  = '{1, mk_in(1,1,9,'h12,7,1,0,0,0,0,0),                mk_exp(1,1,'h77,0,'h40,0,1,5,1,0)};
    vt[5]  = '{1, mk_in(1,1,'h100,'h13,8,1,1,1,0,0,0),            mk_exp(1,1,9,0,'h12,0,0,7,1,0)};
    vt[6]  = '{1, mk_in(1,1,'hBAD,'hBAD,1,1,0,0,0,0,0),           mk_exp(0,0,'h100,0,'h13,1,0,8,0,0)};
    vt[7]  = '{1, idle,                                           mk_exp(0,0,'h100,0,'h13,1,0,8,0,0)};
    vt[8]  = '{1, mk_in(1,0,0,0,0,0,0,0,DB,1,0),                  mk_exp(0,0,'h100,0,'h13,1,0,8,0,0)};
    vt[9]  = '{1, idle,                                           mk_exp(1,1,'h100,DB,'h13,1,0,8,1,0)};
    vt[10] = '{1, mk_in(1,0,0,0,0,0,0,0,'h1234,1,0),              mk_exp(1,0,'h100,DB,'h13,1,0,8,0,0)};
    vt[11] = '{1, mk_in(1,1,'h55,'h55,2,1,0,0,0,0,1),             mk_exp(1,0,'h100,DB,'h13,1,0,8,0,0)};
    vt[12] = '{1, idle,                                           mk_exp(1,0,'h100,DB,'h13,1,0,8,0,0)};
    vt[13] = '{1, mk_in(1,1,'h200,'h20,9,1,1,1,0,0,0),            mk_exp(1,0,'h100,DB,'h13,1,0,8,0,0)};
    vt[14] = '{1, mk_in(1,0,0,0,0,0,0,0,'hCAFE,1,1),              mk_exp(0,0,'h200,DB,'h20,1,0,9,0,0)};
    vt[15] = '{1, idle,                                           mk_exp(1,0,'h200,DB,'h20,1,0,9,0,0)};
    vt[16] = '{1, mk_in(1,1,'hA,'h21,10,0,0,3,0,0,0),             mk_exp(1,0,'h200,DB,'h20,1,0,9,0,0)};
    vt[17] = '{1, idle,                                           mk_exp(1,1,'hA,DB,'h21,0,1,10,0,0)};
    vt[18] = '{1, mk_in(1,1,'hB,'h22,11,1,0,0,0,0,0),             mk_exp(1,0,'hA,DB,'h21,0,1,10,0,0)};
    vt[19] = '{1, mk_in(1,0,0,0,0,0,0,0,0,0,1),                   mk_exp(1,1,'hB,DB,'h22,0,0,11,1,0)};
    vt[20] = '{1, idle,                                           mk_exp(1,0,'hB,DB,'h22,0,0,11,0,0)};

    for (int k = 0; k < 21; k++)
      cycle(vt[k].i, vt[k].chk, vt[k].e, $sformatf("vec%0d", k));

    // Load that never sees data: times out after TMO wait cycles
    e = mk_exp(1,0,'hB,DB,'h22,0,0,11,0,0);
    cycle(mk_in(1,1,'h300,'h30,12,1,1,1,0,0,0), 1, e, "tmo_acc");
    e = mk_exp(0,0,'h300,DB,'h30,1,0,12,0,0);
    for (int k = 1; k <= TMO; k++) cycle(idle, 1, e, $sformatf("tmo_wait%0d", k));
    e = mk_exp(1,1,'h300,DB,'h30,1,0,12,0,1);
    cycle(idle, 1, e, "tmo_pulse");
    e.wv = 1'b0;
    for (int k = 0; k < 3; k++) cycle(idle, 1, e, $sformatf("tmo_sticky%0d", k));

    // Reset while a load is pending: no writeback, sticky error cleared
    cycle(mk_in(1,1,'h400,'h40,13,1,1,1,0,0,0), 1, e, "rst_acc");
    e = mk_exp(0,0,'h400,DB,'h40,1,0,13,0,1);
    cycle(mk_in(0,0,0,0,0,0,0,0,0,0,0), 1, e, "rst_wait");
    e = mk_exp(1,0,0,0,0,0,0,0,0,0);
    for (int k = 0; k < 3; k++) cycle(idle, 1, e, $sformatf("rst_after%0d", k));

    // Random traffic checked against the model
    for (int k = 0; k < 3000; k++) begin
      ri = mk_in(($urandom_range(199) != 0), ($urandom_range(3) != 0), $urandom, $urandom,
                 6'($urandom), 1'($urandom), ($urandom_range(2) == 0), 2'($urandom),
                 $urandom, ($urandom_range(7) == 0), ($urandom_range(11) == 0));
      cycle(ri, 1, m_out, $sformatf("rnd%0d", k));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
